// File: rtl/gpio_mul_pkg.sv
// gpio_mul_pkg: register offsets, status bit indices, FSM states and popcount helper
package gpio_mul_pkg;
    localparam logic [15:0] OFF_A1  = 16'h00;
    localparam logic [15:0] OFF_A2  = 16'h08;
    localparam logic [15:0] OFF_W   = 16'h10;
    localparam logic [15:0] OFF_WH  = 16'h18;
    localparam logic [15:0] OFF_L   = 16'h20;
    localparam logic [15:0] OFF_B   = 16'h28;
    localparam logic [15:0] OFF_GPO = 16'h30;
    localparam logic [15:0] OFF_GPI = 16'h38;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_REJ  = 3;
    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c += 6'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/gpio_mul_if.sv
// gpio_mul_if: srd/swr host bus plus GPIO pins of the multiplier peripheral
interface gpio_mul_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] gpio_out;
    modport master (output saddress, srd, swr, sdata_in, gpio_in, gpio_latch,
                    input sdata_out, gpio_out);
    modport slave (input saddress, srd, swr, sdata_in, gpio_in, gpio_latch,
                   output sdata_out, gpio_out);
endinterface

// File: rtl/gpio_mul_core.sv
// gpio_mul_core: one-bit-per-cycle shift-add multiplier, OP_W steps after start
module gpio_mul_core #(
    parameter int OP_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [2*OP_W-1:0] res,
    output logic              last
);
    localparam int CW = $clog2(OP_W);
    logic [2*OP_W-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [OP_W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              run_q, run_d;
    // last marks the final accumulate step; res is complete on the next cycle
    always_comb begin
        last     = run_q && cnt_q == CW'(OP_W - 1);
        mcand_d  = start ? (2*OP_W)'(a) : mcand_q;
        mplier_d = start ? b : run_q ? mplier_q >> 1 : mplier_q;
        acc_d    = start ? '0 : (run_q && mplier_q[0]) ? acc_q + (mcand_q << cnt_q) : acc_q;
        cnt_d    = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
        run_d    = start ? 1'b1 : last ? 1'b0 : run_q;
        res      = acc_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/gpio_mul_engine.sv
// gpio_mul_engine: bus-mapped sequential multiplier with GPIO registers.
// Define GPIOMUL_POPCNT_EN to build the popcount of W into register L.
module gpio_mul_engine
    import gpio_mul_pkg::*;
#(
    parameter int          OP_W      = 24,
    parameter logic [15:0] BASE_ADDR = 16'h0430
) (
    input logic       clk,
    input logic       reset,
    gpio_mul_if.slave bus
);
    state_t            state_q, state_d;
    logic [OP_W-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic [31:0]       w_q, w_d, wh_q, wh_d, gpo_q, gpo_d, gpi_q, gpi_d, sdo_q, sdo_d;
    logic [5:0]        l_q, l_d;
    logic              done_q, done_d, ovf_q, ovf_d, rej_q, rej_d;
    logic [15:0]       off;
    logic [31:0]       rd_data, status;
    logic [63:0]       res64;
    logic [2*OP_W-1:0] core_res;
    logic              core_last, busy, start, fin, wr_op;
    gpio_mul_core #(.OP_W(OP_W)) u_core (
        .clk(clk), .reset(reset), .start(start), .a(a1_q), .b(bus.sdata_in[OP_W-1:0]),
        .res(core_res), .last(core_last)
    );
    always_comb begin
        off     = bus.saddress - BASE_ADDR;
        busy    = state_q != IDLE;
        fin     = state_q == FIN;
        res64   = 64'(core_res);
        wr_op   = bus.swr && (off == OFF_A1 || off == OFF_A2);
        start   = bus.swr && off == OFF_A2 && !busy;
        state_d = state_q == IDLE ? (start ? MUL : IDLE) :
                  state_q == MUL ? (core_last ? FIN : MUL) : IDLE;
        a1_d    = (bus.swr && off == OFF_A1 && !busy) ? bus.sdata_in[OP_W-1:0] : a1_q;
        a2_d    = start ? bus.sdata_in[OP_W-1:0] : a2_q;
        w_d     = fin ? res64[31:0] : w_q;
        wh_d    = fin ? res64[63:32] : wh_q;
`ifdef GPIOMUL_POPCNT_EN
        l_d     = fin ? popcount(res64[31:0]) : l_q;
`else
        l_d     = '0;
`endif
        done_d  = start ? 1'b0 : fin ? 1'b1 : done_q;
        ovf_d   = start ? 1'b0 : fin ? res64[63:32] != '0 : ovf_q;
        rej_d   = (wr_op && busy) ? 1'b1 :
                  (bus.swr && off == OFF_B && bus.sdata_in[ST_REJ]) ? 1'b0 : rej_q;
        gpo_d   = (bus.swr && off == OFF_GPO) ? bus.sdata_in : gpo_q;
        gpi_d   = bus.gpio_latch ? bus.gpio_in : gpi_q;
        status  = '0;
        status[ST_BUSY] = busy;
        status[ST_DONE] = done_q;
        status[ST_OVF]  = ovf_q;
        status[ST_REJ]  = rej_q;
        // reads sample current (pre-write) register contents
        rd_data = off == OFF_A1  ? 32'(a1_q) :
                  off == OFF_A2  ? 32'(a2_q) :
                  off == OFF_W   ? w_q :
                  off == OFF_WH  ? wh_q :
                  off == OFF_L   ? 32'(l_q) :
                  off == OFF_B   ? status :
                  off == OFF_GPO ? gpo_q :
                  off == OFF_GPI ? gpi_q : '0;
        sdo_d   = bus.srd ? rd_data : sdo_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            w_q     <= '0;
            wh_q    <= '0;
            l_q     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rej_q   <= 1'b0;
            gpo_q   <= '0;
            gpi_q   <= '0;
            sdo_q   <= '0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            w_q     <= w_d;
            wh_q    <= wh_d;
            l_q     <= l_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            rej_q   <= rej_d;
            gpo_q   <= gpo_d;
            gpi_q   <= gpi_d;
            sdo_q   <= sdo_d;
        end
    end
    assign bus.sdata_out = sdo_q;
    assign bus.gpio_out  = gpo_q;
endmodule
